rst_sync_counter: RTL and testbench
===================================

Name: rst_sync_counter

Overview:
- Parametrised successor to the team's single-flop reset-sync counter.
- Contains an N-stage reset synchroniser (asynchronous assert, synchronous deassert) driving a configurable counter with these features: width, up/down, load, clear, wrap or saturate at a programmable maximum, and a terminal-count pulse.
- Used as the standard event/timebase counter in any block that takes a raw board reset.

Parameters:
- WIDTH, 8, counter width in bits (≥2).
- SYNC_STAGES, 2, reset synchroniser depth (≥2).
- MAX_VAL, 2**WIDTH-1, upper count bound; must be ≤ 2**WIDTH-1 and > RST_VAL.
- RST_VAL, 0, value taken on reset and on clr.
- SATURATE, 0, boundary mode: 0 = wrap, 1 = saturate.

Ports:
- clk  input  1  sole clock; all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset; may assert or deassert at any time relative to clk.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- clr  input  1  synchronous clear to RST_VAL.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle.
- ready  output  1  high once the synchronised reset is released.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: count = RST_VAL, tc = 0, ready = 0.
- Reset synchroniser:
  - A chain of SYNC_STAGES flops, all cleared asynchronously by rst_n low; the first stage shifts in 1 each edge.
  - ready = last stage.
  - After rst_n rises, ready goes 1 on the SYNC_STAGES-th rising clk edge (2 edges at default).
- Startup: while ready = 0, count is held at RST_VAL, tc = 0, and en/up/load/clr are ignored.
- Reset mid-operation: rst_n low at any time forces count, tc and ready to reset values immediately, without a clock. The release sequence then restarts from stage 0.
- Operation when ready = 1, evaluated at each rising edge. Priority is clr > load > en:
  - clr: count <= RST_VAL. No tc.
  - load: count <= load_val. If load_val > MAX_VAL, count <= MAX_VAL (clamp). No tc.
  - en & up:
    - If count < MAX_VAL: count+1.
    - If count == MAX_VAL: count <= 0 when wrapping; holds MAX_VAL when saturating.
  - en & !up:
    - If count > 0: count-1.
    - If count == 0: count <= MAX_VAL when wrapping; holds 0 when saturating.
  - en = 0: hold.
- Terminal count (tc):
  - tc = 1 in the cycle after an enabled step taken from a boundary in the step direction (MAX_VAL with up, 0 with down). This applies in both modes.
  - In wrap mode, tc therefore coincides with the wrapped value appearing on count.
  - In saturate mode, tc repeats every cycle while en stays high at the boundary.
- Arithmetic: unsigned, WIDTH bits. No intermediate overflow is allowed to leak; boundary compares are done before the add/subtract.
- Count values above MAX_VAL are unreachable.

Optional Feature:
- Macro: RSC_OVF_CNT_EN.
- Defined:
  - Adds parameter OVF_W (default 4) and output ovf_cnt [OVF_W].
  - ovf_cnt is a saturating count of tc pulses, reset to 0 by rst_n and by clr, unaffected by load.
  - It increments in the same cycle tc is high.
  - It sticks at 2**OVF_W-1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package rsc_pkg: mode constants RSC_WRAP = 0 and RSC_SAT = 1; default width/stage constants; a function that clamps a load value to MAX_VAL.
- Sub-module rst_sync: the SYNC_STAGES reset synchroniser (ports clk, rst_n, rst_sync_n). It is reused by other blocks.
- The counter and tc logic stay in the top module.

Test Plan:
1. Reset release:
   - Stimulus: hold rst_n = 0 for 5 cycles, then release 3 ns after an edge, with en = 1.
   - Required: ready = 0 for the first edge and 1 from the 2nd edge. count stays 0 until ready is 1, then counts 1, 2, 3.
2. Wrap up and down (WIDTH = 4, MAX_VAL = 9, SATURATE = 0):
   - Stimulus: en = 1, up = 1 from 0.
   - Required: count runs 8, 9, 0, and tc = 1 exactly in the cycle count shows 0.
   - Then up = 0 from 0: count shows 9 with tc = 1.
3. Saturate (SATURATE = 1, MAX_VAL = 9):
   - Stimulus: count up to 9, hold en = 1 for 3 more cycles.
   - Required: count stays 9 and tc = 1 on each of those 3 cycles.
   - Then up = 0 to 0 and beyond: count holds 0 and tc pulses.
4. Priority and clamp:
   - Stimulus: clr = 1, load = 1, en = 1 in the same cycle.
   - Required: count = RST_VAL, tc = 0.
   - Then load = 1 with load_val = 15 at MAX_VAL = 9: count = 9.
5. Async reset mid-count:
   - Stimulus: at count = 6, pulse rst_n low for 1 ns between edges.
   - Required: count = 0, ready = 0 and tc = 0 immediately. ready is 1 again after 2 edges and counting resumes from 0.
6. RSC_OVF_CNT_EN (OVF_W = 2):
   - Stimulus: force 5 wraps.
   - Required: ovf_cnt = 1, 2, 3, 3, 3. Then clr sets ovf_cnt = 0; load leaves it unchanged.

Source files
------------

// File: rtl/rsc_pkg.sv
// Shared constants and helpers for the reset-synchronised counter.
// Mode encodings, default sizes and the load clamp function.
package rsc_pkg;

  localparam int RSC_WRAP = 0;
  localparam int RSC_SAT  = 1;

  localparam int RSC_DEF_WIDTH  = 8;
  localparam int RSC_DEF_STAGES = 2;

  function automatic logic [31:0] rsc_clamp(
    input logic [31:0] v,
    input logic [31:0] max_v
  );
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asynchronous assert, synchronous deassert.
// rst_sync_n rises SYNC_STAGES edges after rst_n is released.
module rst_sync
  import rsc_pkg::*;
#(
  parameter int SYNC_STAGES = RSC_DEF_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sync_counter.sv
// Event/timebase counter behind an N-stage reset synchroniser.
// Define RSC_OVF_CNT_EN to add the saturating ovf_cnt output.
module rst_sync_counter
  import rsc_pkg::*;
#(
  parameter int          WIDTH       = RSC_DEF_WIDTH,
  parameter int          SYNC_STAGES = RSC_DEF_STAGES,
  parameter int unsigned MAX_VAL     = 2**WIDTH-1,
  parameter int unsigned RST_VAL     = 0,
  parameter int          SATURATE    = RSC_WRAP
`ifdef RSC_OVF_CNT_EN
  ,
  parameter int          OVF_W       = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
`ifdef RSC_OVF_CNT_EN
  output logic [OVF_W-1:0] ovf_cnt,
`endif
  output logic             ready
);

  localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_W = RST_VAL[WIDTH-1:0];

  logic             rdy;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic [31:0]      clamp_w;
  logic             at_max, at_zero;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_sync_n(rdy)
  );

  assign clamp_w = rsc_clamp(32'(load_val), MAX_VAL);

  // Boundary compares happen before the step so nothing overflows
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    at_max  = (count_q == MAX_W);
    at_zero = (count_q == '0);
    if (!rdy) begin
      count_d = RST_W;
    end else if (clr) begin
      count_d = RST_W;
    end else if (load) begin
      count_d = clamp_w[WIDTH-1:0];
    end else if (en) begin
      if (up) begin
        tc_d = at_max;
        if (!at_max)                count_d = count_q + WIDTH'(1);
        else if (SATURATE == RSC_WRAP) count_d = '0;
      end else begin
        tc_d = at_zero;
        if (!at_zero)               count_d = count_q - WIDTH'(1);
        else if (SATURATE == RSC_WRAP) count_d = MAX_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_W;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ready = rdy;

`ifdef RSC_OVF_CNT_EN
  logic [OVF_W-1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (rdy && clr)             ovf_d = '0;
    else if (tc_d && ovf_q != '1) ovf_d = ovf_q + OVF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign ovf_cnt = ovf_q;
`endif

endmodule

// File: tb/tb_rst_sync_counter.sv
// Bench: wrap and saturate instances against a behavioural model.
// Randomised traffic plus directed boundary, priority and reset cases.
module tb_rst_sync_counter;

  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       clr = 1'b0;

  logic [3:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, rdy_w, rdy_s;
`ifdef RSC_OVF_CNT_EN
  logic [1:0] ovf_w, ovf_s;
`endif

  int checks = 0;
  int errors = 0;

  int m_cnt[2];
  int m_tc[2];
  int m_ovf[2];
  int m_edges;
  bit m_rdy;

  always #5 clk = ~clk;

  rst_sync_counter #(
    .WIDTH(4), .SYNC_STAGES(2), .MAX_VAL(9), .RST_VAL(0), .SATURATE(0)
`ifdef RSC_OVF_CNT_EN
    , .OVF_W(2)
`endif
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr(clr), .count(cnt_w), .tc(tc_w),
`ifdef RSC_OVF_CNT_EN
    .ovf_cnt(ovf_w),
`endif
    .ready(rdy_w)
  );

  rst_sync_counter #(
    .WIDTH(4), .SYNC_STAGES(2), .MAX_VAL(9), .RST_VAL(0), .SATURATE(1)
`ifdef RSC_OVF_CNT_EN
    , .OVF_W(2)
`endif
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr(clr), .count(cnt_s), .tc(tc_s),
`ifdef RSC_OVF_CNT_EN
    .ovf_cnt(ovf_s),
`endif
    .ready(rdy_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_tc[i]  = 0;
      m_ovf[i] = 0;
    end
    m_edges = 0;
    m_rdy   = 0;
  endtask

  // One clock edge of the reference, from the counting rules directly
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit sat = (i == 1);
      int tc_n = 0;
      if (!m_rdy) begin
        m_cnt[i] = 0;
      end else if (clr) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      end else if (en && up) begin
        if (m_cnt[i] == MAXV) begin
          tc_n = 1;
          m_cnt[i] = sat ? MAXV : 0;
        end else m_cnt[i]++;
      end else if (en) begin
        if (m_cnt[i] == 0) begin
          tc_n = 1;
          m_cnt[i] = sat ? 0 : MAXV;
        end else m_cnt[i]--;
      end
      m_tc[i] = tc_n;
      if (tc_n == 1 && m_ovf[i] < 3) m_ovf[i]++;
    end
    if (rst_n) begin
      m_edges++;
      m_rdy = (m_edges >= 2);
    end
  endtask

  task automatic cmp_all();
    chk("cnt_wrap", int'(cnt_w), m_cnt[0]);
    chk("tc_wrap", int'(tc_w), m_tc[0]);
    chk("rdy_wrap", int'(rdy_w), int'(m_rdy));
    chk("cnt_sat", int'(cnt_s), m_cnt[1]);
    chk("tc_sat", int'(tc_s), m_tc[1]);
    chk("rdy_sat", int'(rdy_s), int'(m_rdy));
`ifdef RSC_OVF_CNT_EN
    chk("ovf_wrap", int'(ovf_w), m_ovf[0]);
    chk("ovf_sat", int'(ovf_s), m_ovf[1]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    cmp_all();
  endtask

  task automatic rst_pulse();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    chk("async_cnt", int'(cnt_w), 0);
    chk("async_rdy", int'(rdy_w), 0);
    chk("async_tc", int'(tc_s), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("rst_cnt", int'(cnt_w), 0);
    chk("rst_tc", int'(tc_w), 0);
    chk("rst_rdy", int'(rdy_w), 0);

    // Release 3 ns after an edge, counting up
    #2 rst_n = 1'b1;
    en = 1'b1;
    up = 1'b1;
    tick();
    chk("rel_e1_rdy", int'(rdy_w), 0);
    chk("rel_e1_cnt", int'(cnt_w), 0);
    tick();
    chk("rel_e2_rdy", int'(rdy_w), 1);
    chk("rel_e2_cnt", int'(cnt_w), 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("rel_cnt", int'(cnt_w), k);
    end

    // Wrap upward 8, 9, 0
    for (int k = 4; k <= 8; k++) tick();
    chk("up_8", int'(cnt_w), 8);
    tick();
    chk("up_9", int'(cnt_w), 9);
    chk("up_9_tc", int'(tc_w), 0);
    tick();
    chk("wrap_0", int'(cnt_w), 0);
    chk("wrap_0_tc", int'(tc_w), 1);
    chk("sat_hold9", int'(cnt_s), 9);
    up = 1'b0;
    tick();
    chk("wrap_dn_9", int'(cnt_w), 9);
    chk("wrap_dn_tc", int'(tc_w), 1);

    // Saturate: up from clear, then down past zero
    clr = 1'b1;
    tick();
    clr = 1'b0;
    up  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k >= 10) begin
        chk("sat_top", int'(cnt_s), 9);
        chk("sat_top_tc", int'(tc_s), 1);
      end
    end
    up = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k >= 10) begin
        chk("sat_bot", int'(cnt_s), 0);
        chk("sat_bot_tc", int'(tc_s), 1);
      end
    end

    // Priority clr > load > en, then load clamp
    load_val = 4'd5;
    clr  = 1'b1;
    load = 1'b1;
    tick();
    chk("prio_cnt", int'(cnt_w), 0);
    chk("prio_tc", int'(tc_s), 0);
    clr = 1'b0;
    load_val = 4'd15;
    tick();
    chk("clamp_w", int'(cnt_w), 9);
    chk("clamp_s", int'(cnt_s), 9);

    // Async reset at count 6
    load_val = 4'd6;
    tick();
    load = 1'b0;
    en   = 1'b0;
    chk("pre_rst6", int'(cnt_w), 6);
    rst_pulse();
    en = 1'b1;
    up = 1'b1;
    tick();
    chk("rr_e1_rdy", int'(rdy_w), 0);
    tick();
    chk("rr_e2_rdy", int'(rdy_w), 1);
    tick();
    chk("rr_resume", int'(cnt_w), 1);

`ifdef RSC_OVF_CNT_EN
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      for (int k = 0; k < 10; k++) tick();
      chk("ovf_seq", int'(ovf_w), (w > 3) ? 3 : w);
    end
    clr = 1'b1;
    tick();
    chk("ovf_clr", int'(ovf_w), 0);
    clr = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    en = 1'b0;
    load = 1'b1;
    load_val = 4'd3;
    tick();
    load = 1'b0;
    chk("ovf_load", int'(ovf_w), 1);
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      en   = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 15) == 0) up = ~up;
      load = ($urandom_range(0, 19) == 0);
      clr  = ($urandom_range(0, 29) == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) rst_pulse();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
